// File: rtl/stage4_mem.sv
`default_nettype none
// ============================================================================
// Module   : stage4_mem
// Purpose  : Memory-access stage of the 10-bit pipelined CPU. Loads and
//            stores are serviced through a direct-mapped, write-through,
//            one-word-per-line data cache placed in front of a slow external
//            RAM that uses a req/ack handshake. The stage stalls the execute
//            stage through cache_Ready and holds its M pipeline register
//            during a stall, so forwarding from M stays correct.
//
// Ports    : clk, reset (async, active-low)
//            EX side  : ALU_result (address / result), rt_out (store data),
//                       reg_write_en_in, RAM_writeEnable_in (store),
//                       MemtoReg_in (load), reg_writesel_in, PC_en_in
//            RAM side : ram_req, ram_we, ram_addr, ram_wdata (registered),
//                       ram_rdata, ram_ack (one-cycle completion)
//            Stall    : cache_Ready (combinational, 1 = advance)
//            M reg    : ALU_M, Mem_M, MemtoReg_M, reg_write_en_M,
//                       write_sel_M, PC_en_out
//
// Revision : 1.0 - initial release
// ============================================================================
module stage4_mem #(
    parameter int DATA_W  = 10,
    parameter int INDEX_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    // Execute-stage pipeline register outputs
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] rt_out,
    input  logic              reg_write_en_in,
    input  logic              RAM_writeEnable_in,
    input  logic              MemtoReg_in,
    input  logic [2:0]        reg_writesel_in,
    input  logic              PC_en_in,
    // External RAM handshake
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              ram_req,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    // Stall back to the execute stage
    output logic              cache_Ready,
    // M pipeline register
    output logic [DATA_W-1:0] ALU_M,
    output logic [DATA_W-1:0] Mem_M,
    output logic              MemtoReg_M,
    output logic              reg_write_en_M,
    output logic [2:0]        write_sel_M,
    output logic              PC_en_out
);

    localparam int c_LINES = 1 << INDEX_W;
    localparam int c_TAG_W = DATA_W - INDEX_W;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_WAIT = 2'd1;
    localparam logic [1:0] c_WR_WAIT = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    // ------------------------------------------------------------------------
    // Cache storage. Only the valid bits need a reset; tag and data contents
    // are meaningless while the matching valid bit is clear.
    // ------------------------------------------------------------------------
    logic [c_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag  [c_LINES];
    logic [DATA_W-1:0]  r_data [c_LINES];

    logic [1:0]         r_state;

    // ------------------------------------------------------------------------
    // Request decode and lookup
    // ------------------------------------------------------------------------
    logic [INDEX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_store;
    logic               w_load;
    logic               w_hit;
    logic [DATA_W-1:0]  w_line_data;
    logic               w_fill;
    logic               w_wr_update;

    assign w_idx       = ALU_result[INDEX_W-1:0];
    assign w_tag       = ALU_result[DATA_W-1:INDEX_W];
    assign w_store     = RAM_writeEnable_in;
    // A store wins when both controls are set.
    assign w_load      = MemtoReg_in & ~RAM_writeEnable_in;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line_data = r_data[w_idx];

    // Line writes happen only on the ack edge of a wait state. A store that
    // misses allocates nothing (no-write-allocate).
    assign w_fill      = (r_state == c_RD_WAIT) && ram_ack;
    assign w_wr_update = (r_state == c_WR_WAIT) && ram_ack && w_hit;

    // ------------------------------------------------------------------------
    // Stall decode. In IDLE the stall is raised in the same cycle a miss or
    // store is seen; DONE releases the pipeline for exactly one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        cache_Ready = 1'b0;
        case (r_state)
            c_IDLE:  cache_Ready = ~(w_store | (w_load & ~w_hit));
            c_DONE:  cache_Ready = 1'b1;
            default: cache_Ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM and RAM request registers. The request fields are captured
    // when leaving IDLE, so they stay stable until the ack is sampled; the
    // request drops on the ack edge itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_valid   <= '0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_store) begin
                        r_state   <= c_WR_WAIT;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_addr  <= ALU_result;
                        ram_wdata <= rt_out;
                    end else if (w_load && !w_hit) begin
                        r_state   <= c_RD_WAIT;
                        ram_req   <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= ALU_result;
                    end
                end
                c_RD_WAIT: begin
                    if (ram_ack) begin
                        r_valid[w_idx] <= 1'b1;
                        ram_req        <= 1'b0;
                        r_state        <= c_DONE;
                    end
                end
                c_WR_WAIT: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // The instruction already completed; no second lookup.
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tag and data arrays. Writes are qualified by FSM state, which is held
    // in IDLE while reset is asserted, so an interrupted fill never lands.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= ram_rdata;
        end else if (w_wr_update) begin
            r_data[w_idx] <= rt_out;
        end
    end

    // ------------------------------------------------------------------------
    // M pipeline register. Loads only when the pipeline advances. For a load
    // the line data is the hit data in IDLE or the freshly filled word in
    // DONE; otherwise the store/pass-through operand is forwarded.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALU_M          <= '0;
            Mem_M          <= '0;
            MemtoReg_M     <= 1'b0;
            reg_write_en_M <= 1'b0;
            write_sel_M    <= 3'd0;
            PC_en_out      <= 1'b0;
        end else if (cache_Ready) begin
            ALU_M          <= ALU_result;
            Mem_M          <= w_load ? w_line_data : rt_out;
            MemtoReg_M     <= MemtoReg_in;
            reg_write_en_M <= reg_write_en_in;
            write_sel_M    <= reg_writesel_in;
            PC_en_out      <= PC_en_in;
        end
    end

endmodule
`default_nettype wire
